// File: rtl/baud_rate_generator.sv
// SPI baud rate generator: derives SCLK from PCLK using a prescaler/rate divisor and
// produces one-cycle send/receive strobes in the PCLK cycle just before each SCLK edge.
module baud_rate_generator (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [1:0]  spi_mode_i,
  input  logic        spiswai_i,
  input  logic [2:0]  sppr_i,
  input  logic [2:0]  spr_i,
  input  logic        cpol_i,
  input  logic        cphase_i,
  input  logic        ss_i,
  output logic        sclk_o,
  output logic        miso_receive_sclk0_o,
  output logic        miso_receive_sclk_o,
  output logic        mosi_send_sclk0_o,
  output logic        mosi_send_sclk_o,
  output logic [11:0] baudratedivisor_o
);

  localparam logic [1:0] ModeRun  = 2'b00;
  localparam logic [1:0] ModeWait = 2'b01;

  logic [3:0]  w_prescale;
  logic [11:0] w_divisor;
  logic [10:0] w_half;
  logic [10:0] w_half_m1;
  logic        w_active;
  logic        w_wrap;
  logic        w_tick;
  logic        w_same_phase;

  logic [10:0] r_cnt;
  logic        r_sclk;

  // Divisor and half-period from the prescaler and rate selects.
  always_comb begin
    w_prescale = {1'b0, sppr_i} + 4'd1;
    w_divisor  = {8'd0, w_prescale} << ({1'b0, spr_i} + 4'd1);
    w_half     = {7'd0, w_prescale} << spr_i;
    w_half_m1  = w_half - 11'd1;
  end

  // Activity, end-of-half-period detect and strobe decode.
  always_comb begin
    w_active = ~ss_i & ((spi_mode_i == ModeRun) | ((spi_mode_i == ModeWait) & ~spiswai_i));
    // >= rather than == so a shrinking half-period wraps at once instead of running to overflow.
    w_wrap       = (r_cnt >= w_half_m1);
    // Strobes are held low while reset is asserted, even when H=1 would otherwise tick.
    w_tick       = w_active & w_wrap & ~PRESET;
    w_same_phase = (cpol_i == cphase_i);
  end

  // Half-period counter and SCLK toggle; inactive aborts the half-period and parks SCLK.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_cnt  <= 11'd0;
      r_sclk <= 1'b0;
    end else if (!w_active) begin
      r_cnt  <= 11'd0;
      r_sclk <= cpol_i;
    end else if (w_wrap) begin
      r_cnt  <= 11'd0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + 11'd1;
    end
  end

  assign sclk_o               = r_sclk;
  assign baudratedivisor_o    = w_divisor;
  assign miso_receive_sclk0_o = w_tick & ~r_sclk &  w_same_phase;
  assign miso_receive_sclk_o  = w_tick &  r_sclk & ~w_same_phase;
  assign mosi_send_sclk0_o    = w_tick & ~r_sclk & ~w_same_phase;
  assign mosi_send_sclk_o     = w_tick &  r_sclk &  w_same_phase;

endmodule

// File: tb/tb_baud_rate_generator.sv
// Directed self-checking bench for baud_rate_generator.
module tb_baud_rate_generator;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [1:0]  spi_mode_i;
  logic        spiswai_i;
  logic [2:0]  sppr_i;
  logic [2:0]  spr_i;
  logic        cpol_i;
  logic        cphase_i;
  logic        ss_i;
  logic        sclk_o;
  logic        miso_receive_sclk0_o;
  logic        miso_receive_sclk_o;
  logic        mosi_send_sclk0_o;
  logic        mosi_send_sclk_o;
  logic [11:0] baudratedivisor_o;

  int total = 0;
  int bad   = 0;

  // {sclk, miso_r0, miso_r, mosi_s0, mosi_s}
  logic [4:0] w_obs;
  assign w_obs = {sclk_o, miso_receive_sclk0_o, miso_receive_sclk_o,
                  mosi_send_sclk0_o, mosi_send_sclk_o};

  baud_rate_generator dut (
    .PCLK                 (PCLK),
    .PRESET               (PRESET),
    .spi_mode_i           (spi_mode_i),
    .spiswai_i            (spiswai_i),
    .sppr_i               (sppr_i),
    .spr_i                (spr_i),
    .cpol_i               (cpol_i),
    .cphase_i             (cphase_i),
    .ss_i                 (ss_i),
    .sclk_o               (sclk_o),
    .miso_receive_sclk0_o (miso_receive_sclk0_o),
    .miso_receive_sclk_o  (miso_receive_sclk_o),
    .mosi_send_sclk0_o    (mosi_send_sclk0_o),
    .mosi_send_sclk_o     (mosi_send_sclk_o),
    .baudratedivisor_o    (baudratedivisor_o)
  );

  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic go_idle();
    ss_i = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    PRESET = 1'b1; ss_i = 1'b1; cpol_i = 1'b1; cphase_i = 1'b0;
    spi_mode_i = 2'b00; spiswai_i = 1'b0; sppr_i = 3'd2; spr_i = 3'd1;
    #2;
    total++;
    if (w_obs !== 5'b0_0000) begin
      bad++; $display("FAIL reset_outputs: got %b want %b", w_obs, 5'b0_0000);
    end
    total++;
    if (baudratedivisor_o !== 12'd12) begin
      bad++; $display("FAIL reset_divisor: got %0d want %0d", baudratedivisor_o, 12);
    end
    step();
    total++;
    if (w_obs !== 5'b0_0000) begin
      bad++; $display("FAIL reset_held: got %b want %b", w_obs, 5'b0_0000);
    end
    PRESET = 1'b0;
    step();
    total++;
    if (w_obs !== 5'b1_0000) begin
      bad++; $display("FAIL reset_release_idle: got %b want %b", w_obs, 5'b1_0000);
    end
  endtask

  task automatic test_fast();
    logic [4:0] exp;
    sppr_i = 3'd0; spr_i = 3'd0; cpol_i = 1'b0; cphase_i = 1'b0; spi_mode_i = 2'b00;
    go_idle();
    total++;
    if (baudratedivisor_o !== 12'd2) begin
      bad++; $display("FAIL fast_divisor: got %0d want %0d", baudratedivisor_o, 2);
    end
    ss_i = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp = (k % 2 == 0) ? 5'b0_1000 : 5'b1_0001;
      total++;
      if (w_obs !== exp) begin
        bad++; $display("FAIL fast_cycle%0d: got %b want %b", k, w_obs, exp);
      end
      step();
    end
  endtask

  task automatic test_cpol1();
    logic [4:0] exp;
    sppr_i = 3'd1; spr_i = 3'd1; cpol_i = 1'b1; cphase_i = 1'b1;
    go_idle();
    total++;
    if (baudratedivisor_o !== 12'd8) begin
      bad++; $display("FAIL cpol1_divisor: got %0d want %0d", baudratedivisor_o, 8);
    end
    total++;
    if (w_obs !== 5'b1_0000) begin
      bad++; $display("FAIL cpol1_idle: got %b want %b", w_obs, 5'b1_0000);
    end
    ss_i = 1'b0;
    #1;
    for (int k = 0; k < 12; k++) begin
      case (k)
        3, 11:   exp = 5'b1_0001;
        7:       exp = 5'b0_1000;
        default: exp = ((k / 4) % 2 == 0) ? 5'b1_0000 : 5'b0_0000;
      endcase
      total++;
      if (w_obs !== exp) begin
        bad++; $display("FAIL cpol1_cycle%0d: got %b want %b", k, w_obs, exp);
      end
      step();
    end
  endtask

  task automatic test_max();
    int toggles = 0;
    int first   = 0;
    int n_mr    = 0;
    int n_ms0   = 0;
    int n_other = 0;
    logic prev;
    sppr_i = 3'd7; spr_i = 3'd7; cpol_i = 1'b0; cphase_i = 1'b1;
    go_idle();
    total++;
    if (baudratedivisor_o !== 12'd2048) begin
      bad++; $display("FAIL max_divisor: got %0d want %0d", baudratedivisor_o, 2048);
    end
    ss_i = 1'b0;
    #1;
    prev = sclk_o;
    for (int k = 0; k < 16384; k++) begin
      if (miso_receive_sclk_o) n_mr++;
      if (mosi_send_sclk0_o) n_ms0++;
      if (miso_receive_sclk0_o || mosi_send_sclk_o) n_other++;
      step();
      if (sclk_o !== prev) begin
        toggles++;
        if (first == 0) first = k + 1;
      end
      prev = sclk_o;
    end
    total++;
    if (first != 1024) begin
      bad++; $display("FAIL max_first_toggle: got %0d want %0d", first, 1024);
    end
    total++;
    if (toggles != 16) begin
      bad++; $display("FAIL max_toggles: got %0d want %0d", toggles, 16);
    end
    total++;
    if (n_mr != 8 || n_ms0 != 8 || n_other != 0) begin
      bad++;
      $display("FAIL max_strobes: got mr=%0d ms0=%0d other=%0d want 8 8 0", n_mr, n_ms0, n_other);
    end
    ss_i = 1'b1;
  endtask

  task automatic test_wait();
    sppr_i = 3'd0; spr_i = 3'd2; cpol_i = 1'b0; cphase_i = 1'b0;
    spi_mode_i = 2'b01; spiswai_i = 1'b0;
    go_idle();
    ss_i = 1'b0;
    #1;
    repeat (6) step();
    total++;
    if (w_obs !== 5'b1_0000) begin
      bad++; $display("FAIL wait_mid_period: got %b want %b", w_obs, 5'b1_0000);
    end
    spiswai_i = 1'b1;
    step();
    total++;
    if (w_obs !== 5'b0_0000) begin
      bad++; $display("FAIL wait_halt: got %b want %b", w_obs, 5'b0_0000);
    end
    step();
    total++;
    if (w_obs !== 5'b0_0000) begin
      bad++; $display("FAIL wait_halt_hold: got %b want %b", w_obs, 5'b0_0000);
    end
    spiswai_i = 1'b0;
    #1;
    step();
    step();
    total++;
    if (w_obs !== 5'b0_0000) begin
      bad++; $display("FAIL wait_restart_k2: got %b want %b", w_obs, 5'b0_0000);
    end
    step();
    total++;
    if (w_obs !== 5'b0_1000) begin
      bad++; $display("FAIL wait_restart_tick: got %b want %b", w_obs, 5'b0_1000);
    end
    step();
    total++;
    if (w_obs !== 5'b1_0000) begin
      bad++; $display("FAIL wait_restart_toggle: got %b want %b", w_obs, 5'b1_0000);
    end
    spi_mode_i = 2'b11;
    step();
    total++;
    if (w_obs !== 5'b0_0000) begin
      bad++; $display("FAIL stop_mode: got %b want %b", w_obs, 5'b0_0000);
    end
    spi_mode_i = 2'b00;
    #1;
    repeat (4) step();
    ss_i = 1'b1;
    #1;
    total++;
    if (w_obs !== 5'b1_0000) begin
      bad++; $display("FAIL ss_rise_comb: got %b want %b", w_obs, 5'b1_0000);
    end
    step();
    total++;
    if (w_obs !== 5'b0_0000) begin
      bad++; $display("FAIL ss_rise_park: got %b want %b", w_obs, 5'b0_0000);
    end
  endtask

  task automatic test_spr_change();
    sppr_i = 3'd0; spr_i = 3'd3; cpol_i = 1'b0; cphase_i = 1'b1;
    spi_mode_i = 2'b00; spiswai_i = 1'b0;
    go_idle();
    ss_i = 1'b0;
    #1;
    repeat (6) step();
    total++;
    if (w_obs !== 5'b0_0000) begin
      bad++; $display("FAIL spr_before: got %b want %b", w_obs, 5'b0_0000);
    end
    spr_i = 3'd0;
    #1;
    total++;
    if (w_obs !== 5'b0_0010) begin
      bad++; $display("FAIL spr_shrink_tick: got %b want %b", w_obs, 5'b0_0010);
    end
    total++;
    if (baudratedivisor_o !== 12'd2) begin
      bad++; $display("FAIL spr_divisor: got %0d want %0d", baudratedivisor_o, 2);
    end
    step();
    total++;
    if (w_obs !== 5'b1_0100) begin
      bad++; $display("FAIL spr_toggle: got %b want %b", w_obs, 5'b1_0100);
    end
    step();
    total++;
    if (w_obs !== 5'b0_0010) begin
      bad++; $display("FAIL spr_next: got %b want %b", w_obs, 5'b0_0010);
    end
  endtask

  task automatic test_preset_mid();
    sppr_i = 3'd0; spr_i = 3'd0; cpol_i = 1'b1; cphase_i = 1'b0;
    go_idle();
    ss_i = 1'b0;
    #1;
    total++;
    if (w_obs !== 5'b1_0100) begin
      bad++; $display("FAIL preset_pre_k0: got %b want %b", w_obs, 5'b1_0100);
    end
    step();
    step();
    total++;
    if (w_obs !== 5'b1_0100) begin
      bad++; $display("FAIL preset_pre_k2: got %b want %b", w_obs, 5'b1_0100);
    end
    PRESET = 1'b1;
    #1;
    total++;
    if (w_obs !== 5'b0_0000) begin
      bad++; $display("FAIL preset_async: got %b want %b", w_obs, 5'b0_0000);
    end
    step();
    total++;
    if (w_obs !== 5'b0_0000) begin
      bad++; $display("FAIL preset_held: got %b want %b", w_obs, 5'b0_0000);
    end
    PRESET = 1'b0;
    #1;
    total++;
    if (w_obs !== 5'b0_0010) begin
      bad++; $display("FAIL preset_release: got %b want %b", w_obs, 5'b0_0010);
    end
    step();
    total++;
    if (w_obs !== 5'b1_0100) begin
      bad++; $display("FAIL preset_resume: got %b want %b", w_obs, 5'b1_0100);
    end
    ss_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fast();
    test_cpol1();
    test_max();
    test_wait();
    test_spr_change();
    test_preset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
